// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multi-cycle ALU for the EX stage.
// Single-cycle ops (add/sub/logic/compare/shift) complete through a one-cycle
// DONE state. MULT is an iterative shift-add and DIV an iterative restoring
// divide, both WIDTH iterations, both writing {HI,LO}. busy stalls the pipe.
// Optional feature: define SIGNED_MULDIV_EN to add MULTS (1110) and DIVS
// (1111) in two's complement; without it those codes are unknown opcodes.
module ula_multiciclo #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [2*WIDTH-1:0]   hilo,
    output logic                 hilo_we,
    output logic                 flag,
    output logic                 div_zero
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_MULT  = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_SLT   = 4'b0110;
    localparam logic [3:0] OP_SGT   = 4'b0111;
    localparam logic [3:0] OP_SEQ   = 4'b1000;
    localparam logic [3:0] OP_SLE   = 4'b1001;
    localparam logic [3:0] OP_SGE   = 4'b1010;
    localparam logic [3:0] OP_SLL   = 4'b1011;
    localparam logic [3:0] OP_SRL   = 4'b1100;
    localparam logic [3:0] OP_SNE   = 4'b1101;
`ifdef SIGNED_MULDIV_EN
    localparam logic [3:0] OP_MULTS = 4'b1110;
    localparam logic [3:0] OP_DIVS  = 4'b1111;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e               state_q,    state_d;
    logic [3:0]           op_q,       op_d;
    logic [WIDTH-1:0]     a_q,        a_d;
    logic [WIDTH-1:0]     b_q,        b_d;
    logic [2*WIDTH-1:0]   acc_q,      acc_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;
    logic [WIDTH-1:0]     result_q,   result_d;
    logic [2*WIDTH-1:0]   hilo_q,     hilo_d;
    logic                 hilo_we_q,  hilo_we_d;
    logic                 flag_q,     flag_d;
    logic                 div_zero_q, div_zero_d;

`ifdef SIGNED_MULDIV_EN
    logic                 neg_a_q,    neg_a_d;
    logic                 neg_b_q,    neg_b_d;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
`endif

    // Iteration datapath
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_rem_sh;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;

    // Completion values
    logic [WIDTH-1:0]     alu_result;
    logic                 alu_flag;
    logic [2*WIDTH-1:0]   prod_final;
    logic [WIDTH-1:0]     quot_final;
    logic [WIDTH-1:0]     rem_final;
    logic                 op_is_mul;
    logic                 op_is_div;

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign hilo     = hilo_q;
    assign hilo_we  = hilo_we_q;
    assign flag     = flag_q;
    assign div_zero = div_zero_q;

`ifdef SIGNED_MULDIV_EN
    // Operand magnitudes for the signed variants, taken at acceptance
    always_comb begin
        a_abs = a[WIDTH-1] ? -a : a;
        b_abs = b[WIDTH-1] ? -b : b;
    end
`endif

    // One multiply step (acc = {partial, multiplier}) and one restoring divide
    // step (acc = {remainder, dividend/quotient}); divisor and multiplicand in a_q/b_q
    always_comb begin
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next   = {mul_sum, acc_q[WIDTH-1:1]};
        div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff   = div_rem_sh - {1'b0, b_q};
        if (div_diff[WIDTH]) begin
            div_next = {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    // Single-cycle ALU evaluated on the registered operands
    always_comb begin
        alu_result = '0;
        alu_flag   = 1'b0;
        case (op_q)
            OP_ADD: alu_result = a_q + b_q;
            OP_SUB: alu_result = a_q - b_q;
            OP_AND: alu_result = a_q & b_q;
            OP_OR:  alu_result = a_q | b_q;
            OP_SLL: alu_result = a_q << b_q[SHAMT_W-1:0];
            OP_SRL: alu_result = a_q >> b_q[SHAMT_W-1:0];
            OP_SLT: begin
                alu_flag   = (a_q < b_q);
                alu_result = {{(WIDTH-1){1'b0}}, alu_flag};
            end
            OP_SEQ: begin
                alu_flag   = (a_q == b_q);
                alu_result = {{(WIDTH-1){1'b0}}, alu_flag};
            end
            OP_SGT: alu_flag = (a_q > b_q);
            OP_SLE: alu_flag = (a_q <= b_q);
            OP_SGE: alu_flag = (a_q >= b_q);
            OP_SNE: alu_flag = (a_q != b_q);
            default: begin
                alu_result = '0;
                alu_flag   = 1'b0;
            end
        endcase
    end

    // Final HI/LO values; signed variants get their sign applied here
    always_comb begin
        op_is_mul  = (op_q == OP_MULT);
        op_is_div  = (op_q == OP_DIV);
        prod_final = acc_q;
        quot_final = acc_q[WIDTH-1:0];
        rem_final  = acc_q[2*WIDTH-1:WIDTH];
`ifdef SIGNED_MULDIV_EN
        if (op_q == OP_MULTS) begin
            op_is_mul = 1'b1;
            if (neg_a_q ^ neg_b_q) begin
                prod_final = -acc_q;
            end
        end
        if (op_q == OP_DIVS) begin
            op_is_div = 1'b1;
            if (neg_a_q ^ neg_b_q) begin
                quot_final = -acc_q[WIDTH-1:0];
            end
            if (neg_a_q) begin
                rem_final = -acc_q[2*WIDTH-1:WIDTH];
            end
        end
`endif
    end

    // Next-state and next-output computation for the whole FSM
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hilo_we_d  = 1'b0;
        result_d   = result_q;
        hilo_d     = hilo_q;
        flag_d     = flag_q;
        div_zero_d = div_zero_q;
`ifdef SIGNED_MULDIV_EN
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    a_d   = a;
                    b_d   = b;
                    cnt_d = '0;
                    acc_d = '0;
`ifdef SIGNED_MULDIV_EN
                    neg_a_d = 1'b0;
                    neg_b_d = 1'b0;
`endif
                    case (op)
                        OP_MULT: begin
                            acc_d   = {{WIDTH{1'b0}}, b};
                            state_d = S_MUL;
                            busy_d  = 1'b1;
                        end
                        OP_DIV: begin
                            acc_d = {{WIDTH{1'b0}}, a};
                            if (b == '0) begin
                                state_d = S_DONE;
                            end else begin
                                state_d = S_DIV;
                                busy_d  = 1'b1;
                            end
                        end
`ifdef SIGNED_MULDIV_EN
                        OP_MULTS: begin
                            a_d     = a_abs;
                            b_d     = b_abs;
                            neg_a_d = a[WIDTH-1];
                            neg_b_d = b[WIDTH-1];
                            acc_d   = {{WIDTH{1'b0}}, b_abs};
                            state_d = S_MUL;
                            busy_d  = 1'b1;
                        end
                        OP_DIVS: begin
                            a_d     = a_abs;
                            b_d     = b_abs;
                            neg_a_d = a[WIDTH-1];
                            neg_b_d = b[WIDTH-1];
                            acc_d   = {{WIDTH{1'b0}}, a_abs};
                            if (b == '0) begin
                                state_d = S_DONE;
                            end else begin
                                state_d = S_DIV;
                                busy_d  = 1'b1;
                            end
                        end
`endif
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                end
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                done_d     = 1'b1;
                div_zero_d = 1'b0;
                if (op_is_mul) begin
                    result_d  = '0;
                    flag_d    = 1'b0;
                    hilo_d    = prod_final;
                    hilo_we_d = 1'b1;
                end else if (op_is_div) begin
                    result_d  = '0;
                    flag_d    = 1'b0;
                    hilo_we_d = 1'b1;
                    if (b_q == '0) begin
                        hilo_d     = '0;
                        div_zero_d = 1'b1;
                    end else begin
                        hilo_d = {rem_final, quot_final};
                    end
                end else begin
                    result_d = alu_result;
                    flag_d   = alu_flag;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; synchronous reset abandons any op
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            hilo_q     <= '0;
            hilo_we_q  <= 1'b0;
            flag_q     <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef SIGNED_MULDIV_EN
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            hilo_q     <= hilo_d;
            hilo_we_q  <= hilo_we_d;
            flag_q     <= flag_d;
            div_zero_q <= div_zero_d;
`ifdef SIGNED_MULDIV_EN
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
`endif
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed testbench for ula_multiciclo at WIDTH=32.
// Signed vectors are included when SIGNED_MULDIV_EN is defined.
module tb_ula_multiciclo;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MULT = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SGT  = 4'b0111;
    localparam logic [3:0] OP_SEQ  = 4'b1000;
    localparam logic [3:0] OP_SLE  = 4'b1001;
    localparam logic [3:0] OP_SGE  = 4'b1010;
    localparam logic [3:0] OP_SLL  = 4'b1011;
    localparam logic [3:0] OP_SRL  = 4'b1100;
    localparam logic [3:0] OP_SNE  = 4'b1101;
    localparam logic [3:0] OP_X14  = 4'b1110;
    localparam logic [3:0] OP_X15  = 4'b1111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [63:0] hilo;
    logic        hilo_we;
    logic        flag;
    logic        div_zero;

    int vectors = 0;
    int miscompares = 0;
    int lat;
    int bcnt;
    int wcnt;

    ula_multiciclo #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .hilo     (hilo),
        .hilo_we  (hilo_we),
        .flag     (flag),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op and wait (bounded) for done; lat counts edges after acceptance
    task automatic run(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int l, output int bc);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        l = 0;
        bc = busy ? 1 : 0;
        while (done !== 1'b1 && l < 100) begin
            @(posedge clk); #1;
            l++;
            if (busy) bc++;
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_done",     64'(done),     64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_result",   64'(result),   64'd0);
        check("rst_hilo",     hilo,          64'd0);
        check("rst_hilo_we",  64'(hilo_we),  64'd0);
        check("rst_flag",     64'(flag),     64'd0);
        check("rst_div_zero", 64'(div_zero), 64'd0);
        rst_n = 1'b1;

        // Add / sub
        run(OP_ADD, 32'd7, 32'd5, lat, bcnt);
        check("add_lat",     64'(lat),     64'd1);
        check("add_result",  64'(result),  64'd12);
        check("add_hilo_we", 64'(hilo_we), 64'd0);
        run(OP_SUB, 32'd3, 32'd5, lat, bcnt);
        check("sub_result",  64'(result),  64'hFFFF_FFFE);

        // MULT with carry into HI
        run(OP_MULT, 32'hFFFF_FFFF, 32'd2, lat, bcnt);
        check("mult_lat",     64'(lat),     64'd33);
        check("mult_busy",    64'(bcnt),    64'd32);
        check("mult_hilo",    hilo,         64'h0000_0001_FFFF_FFFE);
        check("mult_hilo_we", 64'(hilo_we), 64'd1);
        check("mult_result",  64'(result),  64'd0);
        tick();
        check("mult_done_pulse", 64'(done),    64'd0);
        check("mult_we_pulse",   64'(hilo_we), 64'd0);

        // Single-cycle op leaves HI/LO untouched
        run(OP_ADD, 32'd1, 32'd1, lat, bcnt);
        check("add2_result",  64'(result), 64'd2);
        check("add2_hilo",    hilo,        64'h0000_0001_FFFF_FFFE);

        // DIV and DIV by zero
        run(OP_DIV, 32'd100, 32'd7, lat, bcnt);
        check("div_lat",      64'(lat),      64'd33);
        check("div_hilo",     hilo,          64'h0000_0002_0000_000E);
        check("div_zero0",    64'(div_zero), 64'd0);
        check("div_hilo_we",  64'(hilo_we),  64'd1);
        run(OP_DIV, 32'd5, 32'd0, lat, bcnt);
        check("div0_lat",     64'(lat),      64'd1);
        check("div0_hilo",    hilo,          64'd0);
        check("div0_flag",    64'(div_zero), 64'd1);
        check("div0_hilo_we", 64'(hilo_we),  64'd1);

        // Compares, logic, shifts
        run(OP_SEQ, 32'd3, 32'd3, lat, bcnt);
        check("seq_flag",     64'(flag),     64'd1);
        check("seq_result",   64'(result),   64'd1);
        check("seq_divz_clr", 64'(div_zero), 64'd0);
        run(OP_SLE, 32'd3, 32'd3, lat, bcnt);
        check("sle_flag",   64'(flag),   64'd1);
        check("sle_result", 64'(result), 64'd0);
        run(OP_SNE, 32'd3, 32'd3, lat, bcnt);
        check("sne_flag",   64'(flag),   64'd0);
        run(OP_SLT, 32'd3, 32'd3, lat, bcnt);
        check("slt_flag",   64'(flag),   64'd0);
        run(OP_SLT, 32'd2, 32'h8000_0000, lat, bcnt);
        check("slt_u_flag",   64'(flag),   64'd1);
        check("slt_u_result", 64'(result), 64'd1);
        run(OP_SGT, 32'd5, 32'd3, lat, bcnt);
        check("sgt_flag",   64'(flag),   64'd1);
        run(OP_SGE, 32'd2, 32'd3, lat, bcnt);
        check("sge_flag",   64'(flag),   64'd0);
        run(OP_SLL, 32'd1, 32'h24, lat, bcnt);
        check("sll_result", 64'(result), 64'h10);
        run(OP_SRL, 32'h8000_0000, 32'h1F, lat, bcnt);
        check("srl_result", 64'(result), 64'd1);
        run(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, lat, bcnt);
        check("and_result", 64'(result), 64'h00F0_1200);
        run(OP_OR, 32'hF000_0001, 32'h0000_1000, lat, bcnt);
        check("or_result",  64'(result), 64'hF000_1001);

`ifndef SIGNED_MULDIV_EN
        run(OP_SGT, 32'd9, 32'd1, lat, bcnt);
        run(OP_X14, 32'd9, 32'd1, lat, bcnt);
        check("unk14_lat",    64'(lat),     64'd1);
        check("unk14_flag",   64'(flag),    64'd0);
        check("unk14_result", 64'(result),  64'd0);
        check("unk14_we",     64'(hilo_we), 64'd0);
        run(OP_X15, 32'd9, 32'd1, lat, bcnt);
        check("unk15_lat",    64'(lat),     64'd1);
        check("unk15_we",     64'(hilo_we), 64'd0);
`endif

        // start held into the DONE cycle is not queued
        op = OP_ADD; a = 32'd1; b = 32'd2; start = 1'b1;
        tick();
        op = OP_SUB; a = 32'd10; b = 32'd1;
        tick();
        start = 1'b0;
        check("hold_done",   64'(done),   64'd1);
        check("hold_result", 64'(result), 64'd3);
        tick();
        check("hold_nodone", 64'(done),   64'd0);
        tick();
        check("hold_nodone2", 64'(done),  64'd0);
        check("hold_keep",   64'(result), 64'd3);

        // MULT with a DIV request at cycle 10: ignored
        op = OP_MULT; a = 32'd6; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        op = OP_DIV; a = 32'd9; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_busy", 64'(busy), 64'd1);
        wcnt = 10;
        while (done !== 1'b1 && wcnt < 100) begin
            tick();
            wcnt++;
        end
        check("ign_lat",  64'(wcnt), 64'd33);
        check("ign_hilo", hilo,      64'd42);
        tick();
        check("ign_no_div", 64'(busy), 64'd0);
        check("ign_no_done", 64'(done), 64'd0);

        // Reset in the middle of a MULT
        op = OP_MULT; a = 32'd5; b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        check("mrst_busy",     64'(busy),     64'd0);
        check("mrst_done",     64'(done),     64'd0);
        check("mrst_hilo",     hilo,          64'd0);
        check("mrst_result",   64'(result),   64'd0);
        check("mrst_flag",     64'(flag),     64'd0);
        check("mrst_div_zero", 64'(div_zero), 64'd0);
        check("mrst_hilo_we",  64'(hilo_we),  64'd0);
        rst_n = 1'b1;
        run(OP_ADD, 32'd20, 32'd22, lat, bcnt);
        check("post_rst_lat",    64'(lat),    64'd1);
        check("post_rst_result", 64'(result), 64'd42);
        tick();
        check("post_rst_idle", 64'(busy), 64'd0);

`ifdef SIGNED_MULDIV_EN
        run(OP_X14, 32'hFFFF_FFFD, 32'd4, lat, bcnt);
        check("mults_lat",  64'(lat), 64'd33);
        check("mults_hilo", hilo,     64'hFFFF_FFFF_FFFF_FFF4);
        run(OP_X15, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        check("divs_lat",   64'(lat), 64'd33);
        check("divs_hilo",  hilo,     64'hFFFF_FFFF_FFFF_FFFD);
        run(OP_X15, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        check("divs_min",   hilo,     64'h0000_0000_8000_0000);
        run(OP_X15, 32'hFFFF_FFF9, 32'd0, lat, bcnt);
        check("divs0_lat",  64'(lat),      64'd1);
        check("divs0_flag", 64'(div_zero), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
